store_narrow_unit: RTL

STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

---
 rtl/store_narrow_unit_pkg.sv | 24 ++
 rtl/store_narrow_unit_byte_lane_merge.sv | 24 ++
 rtl/store_narrow_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/store_narrow_unit_pkg.sv
// Shared store-path types: FSM encoding, store size codes and the alignment rule.
// Pure declarations; no logic, no latency.
package store_narrow_unit_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MERGE_WR = 1'b1
    } snu_state_t;

    typedef enum logic [1:0] {
        SB  = 2'b00,
        SH  = 2'b01,
        SW  = 2'b10,
        RSV = 2'b11
    } store_size_t;

    // A store is bad if its size is reserved or its address is not naturally aligned.
    function automatic logic is_bad_store(input logic [1:0] size, input logic [1:0] lane);
        return (size == RSV) ||
               ((size == SH) && lane[0]) ||
               ((size == SW) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/store_narrow_unit_byte_lane_merge.sv
// Combinational read-modify-write merge: replaces the selected byte or half of old_word.
// Zero latency; no flow control.
module byte_lane_merge
    import store_narrow_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [15:0]           new_data,
    input  logic [1:0]            size,
    input  logic [1:0]            lane,
    output logic [DATA_WIDTH-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SB:      merged[{lane, 3'b000} +: 8]     = new_data[7:0];
            SH:      merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store unit: aligned words write in one cycle; bytes/halves do read-then-merge-write over two
// cycles with stall held for the read cycle only. Flush or reset abort the pending merge write.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_req,
    input  logic [1:0]            store_size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  flush,
    output logic                  stall,
    output logic                  bad_store,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    snu_state_t            state_q, state_d;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic [15:0]           data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  misaligned;
    logic                  sub_word;
    logic                  accept_sub;
    logic [ADDR_WIDTH-1:0] aligned_addr;

    assign misaligned   = is_bad_store(store_size, addr[1:0]);
    assign sub_word     = (store_size == SB) || (store_size == SH);
    assign aligned_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign accept_sub   = (state_q == IDLE) && store_req && sub_word && !misaligned && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            size_q <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else if (accept_sub) begin
            lane_q <= addr[1:0];
            size_q <= store_size;
            data_q <= (store_size == SB) ? {8'h00, store_data[7:0]} : store_data[15:0];
            addr_q <= aligned_addr;
        end
    end

    // The request is still held during MERGE_WR, so that state never re-accepts it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept_sub) state_d = MERGE_WR;
            MERGE_WR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    byte_lane_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .size     (size_q),
        .lane     (lane_q),
        .merged   (merged)
    );

    always_comb begin
        stall     = 1'b0;
        bad_store = 1'b0;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (store_req) begin
                        if (misaligned) begin
                            bad_store = 1'b1;
                        end else if (!flush) begin
                            mem_addr = aligned_addr;
                            if (sub_word) begin
                                mem_re = 1'b1;
                                stall  = 1'b1;
                            end else begin
                                mem_we    = 1'b1;
                                mem_wdata = store_data;
                            end
                        end
                    end
                end
                MERGE_WR: begin
                    if (!flush) begin
                        mem_we    = 1'b1;
                        mem_addr  = addr_q;
                        mem_wdata = merged;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
